// File: rtl/system_switch_edge_pio.sv
// system_switch_edge_pio: Avalon-MM input PIO with per-bit synchroniser,
// debounce filter, sticky edge capture (write-1-to-clear) and a maskable
// level interrupt. Register map: 0 DATA, 1 reserved, 2 IRQ_MASK,
// 3 EDGE_CAPTURE.
module system_switch_edge_pio #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter is at least one bit wide so DEBOUNCE_CYCLES=1 still elaborates.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_e;

    localparam edge_e EDGE_SEL = edge_e'(2'(EDGE_TYPE));

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic [WIDTH-1:0]         prev_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         capture_q, capture_d;
    logic [WIDTH-1:0]         mask_q, mask_d;
    logic [31:0]              readdata_q, readdata_d;

    logic [WIDTH-1:0]         rise, fall, edge_evt, clr;
    logic                     wr_en;
    logic                     unused_writedata;

    assign wr_en = chipselect & ~write_n;

    // Bits of writedata above WIDTH carry no meaning.
    assign unused_writedata = ^(writedata >> WIDTH);

    // Per-bit debounce: accept sync2 only after it differs from the accepted
    // value for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edge event selection and sticky capture; a set wins over a same-cycle clear.
    always_comb begin
        rise = stable_q & ~prev_q;
        fall = ~stable_q & prev_q;
        unique case (EDGE_SEL)
            EDGE_RISE: edge_evt = rise;
            EDGE_FALL: edge_evt = fall;
            default:   edge_evt = rise | fall;
        endcase
        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        capture_d = edge_evt | (capture_q & ~clr);
        mask_d    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    // Read mux, sampled every cycle from the current address (no read strobe).
    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = capture_q;
            default: readdata_d = '0;
        endcase
    end

    // All state registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            capture_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            cnt_q      <= cnt_d;
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_system_switch_edge_pio.sv
// Directed bench for system_switch_edge_pio. Four instances share one bus:
// u0 rising/D=4, u1 falling/D=4, u2 any/D=4, u3 rising/D=1.
module tb_system_switch_edge_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int total;
    int bad;

    system_switch_edge_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    system_switch_edge_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    system_switch_edge_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));
    system_switch_edge_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd3), .irq(irq3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_port = 8'hFF;
        idle(3);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", rd0, 32'h0); end
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq0); end
        reset_n = 1'b1;
        idle(8);
        rd(2'd0);
        total++; if (rd0 !== 32'h000000FF) begin bad++; $display("FAIL post_reset_data got=%h exp=%h", rd0, 32'hFF); end
        rd(2'd3);
        total++; if (rd0 !== 32'h000000FF) begin bad++; $display("FAIL post_reset_cap_rise got=%h exp=%h", rd0, 32'hFF); end
        total++; if (rd1 !== 32'h00000000) begin bad++; $display("FAIL post_reset_cap_fall got=%h exp=%h", rd1, 32'h0); end
        total++; if (rd2 !== 32'h000000FF) begin bad++; $display("FAIL post_reset_cap_any got=%h exp=%h", rd2, 32'hFF); end
        total++; if (rd3 !== 32'h000000FF) begin bad++; $display("FAIL post_reset_cap_d1 got=%h exp=%h", rd3, 32'hFF); end
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL post_reset_irq_masked got=%b exp=0", irq0); end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL w1c_all got=%h exp=%h", rd0, 32'h0); end
    endtask

    task automatic test_debounce();
        logic e0, e3;
        in_port = 8'h00;
        idle(10);
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL deb_irq_idle got=%b exp=0", irq0); end
        in_port = 8'h01;
        for (int k = 0; k <= 6; k++) begin
            tick();
            e0 = (k == 6);
            e3 = (k >= 3);
            total++; if (irq0 !== e0) begin bad++; $display("FAIL deb_latency_d4 edge=%0d got=%b exp=%b", k, irq0, e0); end
            total++; if (irq3 !== e3) begin bad++; $display("FAIL deb_latency_d1 edge=%0d got=%b exp=%b", k, irq3, e3); end
        end
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL deb_fall_no_irq got=%b exp=0", irq1); end
        wr(2'd3, 32'hFF);
        in_port = 8'h03;
        idle(3);
        in_port = 8'h01;
        idle(10);
        rd(2'd0);
        total++; if (rd0 !== 32'h01) begin bad++; $display("FAIL pulse_data got=%h exp=%h", rd0, 32'h01); end
        rd(2'd3);
        total++; if (rd0 !== 32'h00) begin bad++; $display("FAIL pulse_capture got=%h exp=%h", rd0, 32'h00); end
    endtask

    task automatic test_edge_types();
        wr(2'd3, 32'hFF);
        in_port = 8'h09;
        idle(8);
        rd(2'd3);
        total++; if (rd0 !== 32'h08) begin bad++; $display("FAIL edge_rise_t0 got=%h exp=%h", rd0, 32'h08); end
        total++; if (rd1 !== 32'h00) begin bad++; $display("FAIL edge_rise_t1 got=%h exp=%h", rd1, 32'h00); end
        total++; if (rd2 !== 32'h08) begin bad++; $display("FAIL edge_rise_t2 got=%h exp=%h", rd2, 32'h08); end
        wr(2'd3, 32'h08);
        rd(2'd3);
        total++; if (rd2 !== 32'h00) begin bad++; $display("FAIL edge_clear_t2 got=%h exp=%h", rd2, 32'h00); end
        in_port = 8'h01;
        idle(8);
        rd(2'd3);
        total++; if (rd0 !== 32'h00) begin bad++; $display("FAIL edge_fall_t0 got=%h exp=%h", rd0, 32'h00); end
        total++; if (rd1 !== 32'h08) begin bad++; $display("FAIL edge_fall_t1 got=%h exp=%h", rd1, 32'h08); end
        total++; if (rd2 !== 32'h08) begin bad++; $display("FAIL edge_fall_t2 got=%h exp=%h", rd2, 32'h08); end
    endtask

    task automatic test_w1c_collision();
        wr(2'd3, 32'hFF);
        in_port = 8'h0D;
        idle(8);
        rd(2'd3);
        total++; if (rd0 !== 32'h0C) begin bad++; $display("FAIL w1c_setup got=%h exp=%h", rd0, 32'h0C); end
        wr(2'd3, 32'h04);
        rd(2'd3);
        total++; if (rd0 !== 32'h08) begin bad++; $display("FAIL w1c_partial got=%h exp=%h", rd0, 32'h08); end
        in_port = 8'h05;
        idle(8);
        rd(2'd3);
        total++; if (rd0 !== 32'h08) begin bad++; $display("FAIL w1c_hold got=%h exp=%h", rd0, 32'h08); end
        // New rise reaches capture at edge 6 after the input change; clear lands on that edge.
        in_port = 8'h0D;
        idle(6);
        wr(2'd3, 32'h08);
        rd(2'd3);
        total++; if (rd0 !== 32'h08) begin bad++; $display("FAIL w1c_collision got=%h exp=%h", rd0, 32'h08); end
        wr(2'd3, 32'h08);
        rd(2'd3);
        total++; if (rd0 !== 32'h00) begin bad++; $display("FAIL w1c_after got=%h exp=%h", rd0, 32'h00); end
    endtask

    task automatic test_mask();
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h00);
        in_port = 8'h1D;
        idle(8);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL mask_off_irq got=%b exp=0", irq0); end
        rd(2'd3);
        total++; if (rd0 !== 32'h10) begin bad++; $display("FAIL mask_capture got=%h exp=%h", rd0, 32'h10); end
        wr(2'd2, 32'hFFFF_FF10);
        total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL mask_on_irq got=%b exp=1", irq0); end
        rd(2'd2);
        total++; if (rd0 !== 32'h10) begin bad++; $display("FAIL mask_readback got=%h exp=%h", rd0, 32'h10); end
        wr(2'd3, 32'h10);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL mask_clear_irq got=%b exp=0", irq0); end
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reserved_read got=%h exp=%h", rd0, 32'h0); end
    endtask

    task automatic test_async_reset();
        wr(2'd2, 32'h20);
        in_port = 8'h3D;
        idle(8);
        total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL ares_irq_pre got=%b exp=1", irq0); end
        in_port = 8'h1D;
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL ares_irq_async got=%b exp=0", irq0); end
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL ares_readdata_async got=%h exp=%h", rd0, 32'h0); end
        in_port = 8'h00;
        idle(2);
        reset_n = 1'b1;
        idle(8);
        rd(2'd0);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL ares_data got=%h exp=%h", rd0, 32'h0); end
        rd(2'd2);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL ares_mask got=%h exp=%h", rd0, 32'h0); end
        rd(2'd3);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL ares_capture got=%h exp=%h", rd0, 32'h0); end
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL ares_irq_post got=%b exp=0", irq0); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        test_reset();
        test_debounce();
        test_edge_types();
        test_w1c_collision();
        test_mask();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/system_switch_edge_pio.md
# system_switch_edge_pio

Parametrised Avalon-MM input PIO for board switches and push-buttons: it synchronises and debounces a WIDTH-bit input bus, and captures edges into a sticky register that software clears. It raises a maskable level interrupt. It sits on the system interconnect as a slave of the processor, in the same slot as the plain input PIO. It adds debounce, edge capture and IRQ on top of that PIO.

## Interface
- WIDTH, default 8: number of input bits, 1..32.
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before an input change is accepted, 1..65535.
- EDGE_TYPE, default 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- clk  input  1: single clock domain.
- reset_n  input  1: asynchronous active-low reset.
- address  input  2: register select.
- chipselect  input  1: slave select, qualifies writes.
- write_n  input  1: active-low write strobe.
- writedata  input  32: write data. Bits above WIDTH are ignored.
- in_port  input  WIDTH: raw asynchronous switch inputs.
- readdata  output  32: registered read data. Bits above WIDTH are 0.
- irq  output  1: level interrupt, active high.

## Operation
- Register map:
  - 0 DATA: read-only, debounced value.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: read/write, reset 0.
  - 3 EDGE_CAPTURE: read, write-1-to-clear, reset 0.
- Write occurs when chipselect=1 and write_n=0 on a clock edge.
- Synchroniser: two flops per bit, sync1 <= in_port, sync2 <= sync1. Both reset to 0.
- Debounce runs per bit, with counter width clog2(DEBOUNCE_CYCLES). On each edge:
  - if sync2 == stable, cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1, stable <= sync2 and cnt <= 0;
  - else cnt <= cnt+1.
  - Any return to equality restarts the count, so pulses shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect: prev <= stable every cycle. The event vector is:
  - rise = stable & ~prev
  - fall = ~stable & prev
  - selected by EDGE_TYPE.
- Edge capture: capture[i] <= event[i] | (capture[i] & ~clr[i]), where clr = writedata when writing address 3. A set and a clear in the same cycle leave the bit set.
- IRQ_MASK write: mask <= writedata[WIDTH-1:0].
- irq = |(capture & mask). It is combinational from flops, with no extra register.
- readdata is registered every cycle from the mux selected by the current address, as in the existing PIO; no read strobe is used. Write cycles also update readdata.
- Reset values: sync, stable, prev, cnt, capture, mask, readdata are all 0; irq is 0.
- reset_n low mid-operation clears all state asynchronously: irq drops without waiting for a clock, and any pending debounce count is lost.
- An input held high through reset is seen as a 0→1 change and produces a rising capture after release. The mask is 0 at reset, so no spurious irq occurs until software enables it.

## Timing
- Let in_port change settle before clock edge 0 and stay constant.
- sync2 reflects the change after edge 1.
- stable updates at edge DEBOUNCE_CYCLES+1.
- The capture bit sets at edge DEBOUNCE_CYCLES+2, and irq rises in the same cycle if the bit is masked in.
- DATA readdata reflects the new value at edge DEBOUNCE_CYCLES+2 when address=0.
- Read latency is 1: address presented at edge N, readdata valid after edge N+1.
- A write to capture or mask takes effect after the write edge; irq follows in the same cycle.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- With DEBOUNCE_CYCLES=1, a change is accepted on the first cycle it is seen.

## Test plan
- Reset: hold reset_n=0 with in_port=0xFF.
  - Required: readdata=0, irq=0.
  - Release, WIDTH=8, D=4, type 0: DATA reads 0xFF and capture reads 0xFF, with irq=0 because the mask is 0.
- Debounce latency, D=4, type 0, mask=0x01:
  - in_port bit0 0→1 before edge 0: capture[0] and irq go high exactly after edge 6.
  - A 3-cycle pulse 0→1→0 never changes DATA or capture.
- Edge types, bit3 toggled 0→1→0 after stabilisation:
  - type 0: capture=0x08 on the rise only.
  - type 1: capture=0x08 on the fall only.
  - type 2: set on the rise; after a W1C in between, set again on the fall.
- W1C collision: capture=0x0C.
  - Write 0x04 to address 3: result 0x08.
  - Write 0x08 on the same edge as a new bit3 event: bit3 stays 1.
- Mask gating: capture=0x10.
  - mask 0x00: irq=0.
  - Write mask 0x10: irq=1 the next cycle.
  - Write 0x10 to address 3: irq=0 after that edge.
- Async reset mid-debounce: assert reset_n between clock edges while cnt=2 with irq=1.
  - irq falls immediately; all registers read 0 after release, with the input held at 0.
